sisc_fetch_unit: RTL and testbench
==================================

// Module: sisc_fetch_unit
// PURPOSE
//  Instruction fetch stage of the SISC computer, directly upstream of the control FSM.
//  Holds the program counter (PC) and the instruction register (IR), and fetches each instruction
//  from instruction memory over a req/ack handshake.
//  Decodes the IR into opcode, mm, register fields and imm; these feed the ctrl FSM and the datapath.
//  Applies absolute and relative branch targets to the PC when ctrl requests it.
// PARAMETERS
//  PC_W     16      PC and instruction-memory address width
//  RESET_PC 0       PC value after reset
//  TIMEOUT  16      max cycles in WAIT before fetch_err; 0 disables the timeout
// PORTS
//  clk         in   1      clock, rising edge
//  rst_f       in   1      reset, asynchronous, active-low
//  fetch_go    in   1      1-cycle pulse from ctrl in its fetch state
//  pc_write    in   1      ctrl request to load the branch target into PC
//  br_sel      in   1      0: absolute (target = imm); 1: relative (target = pc + sext(imm))
//  imem_req    out  1      instruction memory request
//  imem_addr   out  PC_W   fetch address; stable while imem_req=1
//  imem_ack    in   1      memory data valid; sampled only in WAIT
//  imem_rdata  in   32     instruction word
//  pc          out  PC_W   current PC
//  ir          out  32     instruction register
//  opcode      out  4      ir[31:28]
//  mm          out  4      ir[27:24]
//  rd,rs,rt    out  4 each ir[23:20], ir[19:16], ir[15:12]
//  imm         out  16     ir[15:0]
//  ir_valid    out  1      1-cycle pulse when the IR has been loaded
//  fetch_busy  out  1      1 while in WAIT
//  fetch_err   out  1      sticky; set on handshake timeout
// BEHAVIOUR
//  Reset (async, rst_f=0):
//   - pc=RESET_PC, ir=0 (decodes as NOOP), fetch_addr=RESET_PC.
//   - imem_req=0, ir_valid=0, fetch_err=0, timer=0, state=IDLE.
//  State machine: IDLE, WAIT, ERR (binary encoded, registered).
//  IDLE:
//   - On fetch_go: fetch_addr <= (pc_write ? target : pc); imem_req <= 1; -> WAIT.
//   - pc_write with fetch_go: the branch wins; the fetch starts at the new target.
//   - pc_write without fetch_go: pc <= target on the next edge.
//   - imem_ack is ignored.
//  WAIT:
//   - imem_addr = fetch_addr, held stable; imem_req = 1; timer increments each cycle.
//   - On imem_ack: ir <= imem_rdata; pc <= fetch_addr+1 (mod 2^PC_W); ir_valid=1 on the
//     following cycle only; imem_req <= 0; timer <= 0; -> IDLE.
//   - Latency: ack on the first WAIT cycle gives ir_valid 2 cycles after fetch_go.
//   - fetch_go and pc_write are ignored while busy; ctrl guarantees neither is issued.
//   - Timeout: timer==TIMEOUT-1 with no ack -> ERR. If ack arrives in that same cycle, ack wins.
//  ERR:
//   - fetch_err=1, imem_req=0. All inputs are ignored; only reset exits.
//  Target arithmetic:
//   - absolute: target = imm, zero-extended or truncated to PC_W.
//   - relative: target = pc + sign-extended imm, wraps mod 2^PC_W.
//   - imm is taken from the current ir.
//  Field outputs are combinational from ir and change only when ir loads.
//  Reset mid-WAIT:
//   - imem_req drops asynchronously; the transaction is abandoned.
//   - A late ack arrives in IDLE and is ignored.
//  imem_addr reads 0 outside WAIT.
// STRUCTURE
//  sisc_pkg (shared with ctrl):
//   - opcode constants NOOP..HLT;
//   - am_imm;
//   - IR field bit positions;
//   - fetch state encoding.
//  Sub-module sisc_ir_decode: combinational split of ir into opcode, mm, rd, rs, rt, imm.
//  Everything else (PC, IR, FSM, timer, target adder) lives in this module.
// TESTING
//  1. Reset; fetch_go; memory acks 2 cycles later with 0x10230005 -> imem_addr=0x0000 while req;
//     ir_valid pulses once; opcode=1, mm=0, rd=2, rs=3, imm=0x0005; pc=0x0001.
//  2. ir imm=0x0040, br_sel=0, pc_write in IDLE -> pc=0x0040; next fetch_go drives imem_addr=0x0040.
//  3. Relative branch, pc=0x0010, imm=0xFFFC -> pc=0x000C; pc=0x0002, imm=0xFFFC -> pc=0xFFFE (wrap).
//  4. TIMEOUT=8, fetch_go, ack never given -> fetch_err=1 after 8 WAIT cycles; imem_req=0;
//     later fetch_go and ack produce no ir_valid until reset.
//  5. rst_f low mid-WAIT -> imem_req=0 immediately; pc=RESET_PC; ir=0; an ack 1 cycle after release
//     gives no ir_valid.
//  6. fetch_go and pc_write (br_sel=0, imm=0x0100) in the same cycle from pc=0x0005
//     -> imem_addr=0x0100; after ack, pc=0x0101.

Source files
------------

// File: rtl/sisc_pkg.sv
// sisc_pkg: definitions shared by the SISC fetch unit and control FSM.
//   - opcode constants (NOOP..HLT) and the immediate addressing-mode value
//   - instruction register field bit positions
//   - fetch state encoding (binary, 2 bits)
package sisc_pkg;

  // Opcodes (ir[31:28])
  localparam logic [3:0] OP_NOOP = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_LOD  = 4'h2;
  localparam logic [3:0] OP_STR  = 4'h3;
  localparam logic [3:0] OP_BRA  = 4'h4;
  localparam logic [3:0] OP_BRR  = 4'h5;
  localparam logic [3:0] OP_BNE  = 4'h6;
  localparam logic [3:0] OP_BNR  = 4'h7;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // mm value selecting the immediate operand for ALU ops
  localparam logic [3:0] AM_IMM = 4'b1000;

  // IR field positions
  localparam int IR_OP_MSB  = 31;
  localparam int IR_OP_LSB  = 28;
  localparam int IR_MM_MSB  = 27;
  localparam int IR_MM_LSB  = 24;
  localparam int IR_RD_MSB  = 23;
  localparam int IR_RD_LSB  = 20;
  localparam int IR_RS_MSB  = 19;
  localparam int IR_RS_LSB  = 16;
  localparam int IR_RT_MSB  = 15;
  localparam int IR_RT_LSB  = 12;
  localparam int IR_IMM_MSB = 15;
  localparam int IR_IMM_LSB = 0;

  // Fetch state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

endpackage

// File: rtl/sisc_fetch_unit_if.sv
// sisc_fetch_unit_if: instruction-memory req/ack bus.
//   req   : fetch request, high for the whole transaction
//   addr  : fetch address, stable while req=1 (reads 0 otherwise)
//   ack   : memory data valid
//   rdata : instruction word
// master = fetch unit, slave = instruction memory.
interface sisc_fetch_unit_if #(
  parameter int PC_W = 16
);
  logic            req;
  logic [PC_W-1:0] addr;
  logic            ack;
  logic [31:0]     rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/sisc_ir_decode.sv
// sisc_ir_decode: combinational split of the instruction register.
//   ir_i     : instruction register
//   opcode_o : ir[31:28]   mm_o : ir[27:24]
//   rd_o     : ir[23:20]   rs_o : ir[19:16]   rt_o : ir[15:12]
//   imm_o    : ir[15:0]
module sisc_ir_decode
  import sisc_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic [3:0]  opcode_o,
  output logic [3:0]  mm_o,
  output logic [3:0]  rd_o,
  output logic [3:0]  rs_o,
  output logic [3:0]  rt_o,
  output logic [15:0] imm_o
);

  assign opcode_o = ir_i[IR_OP_MSB:IR_OP_LSB];
  assign mm_o     = ir_i[IR_MM_MSB:IR_MM_LSB];
  assign rd_o     = ir_i[IR_RD_MSB:IR_RD_LSB];
  assign rs_o     = ir_i[IR_RS_MSB:IR_RS_LSB];
  // rt shares its bits with the top nibble of imm
  assign rt_o     = ir_i[IR_RT_MSB:IR_RT_LSB];
  assign imm_o    = ir_i[IR_IMM_MSB:IR_IMM_LSB];

endmodule

// File: rtl/sisc_fetch_unit.sv
// sisc_fetch_unit: SISC instruction fetch stage.
// Holds PC and IR, fetches over a req/ack handshake, decodes the IR and
// applies absolute/relative branch targets to the PC.
// Ports:
//   clk, rst_f    : clock (rising edge), asynchronous active-low reset
//   fetch_go_i    : 1-cycle fetch request from ctrl
//   pc_write_i    : load branch target into PC
//   br_sel_i      : 0 absolute (imm), 1 relative (pc + sext(imm))
//   imem_if       : instruction memory bus (master side)
//   pc_o, ir_o    : current PC and instruction register
//   opcode_o, mm_o, rd_o, rs_o, rt_o, imm_o : IR fields
//   ir_valid_o    : 1-cycle pulse after the IR loads
//   fetch_busy_o  : high while waiting for ack
//   fetch_err_o   : sticky handshake timeout flag (cleared by reset only)
module sisc_fetch_unit
  import sisc_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst_f,
  input  logic                fetch_go_i,
  input  logic                pc_write_i,
  input  logic                br_sel_i,
  sisc_fetch_unit_if.master   imem_if,
  output logic [PC_W-1:0]     pc_o,
  output logic [31:0]         ir_o,
  output logic [3:0]          opcode_o,
  output logic [3:0]          mm_o,
  output logic [3:0]          rd_o,
  output logic [3:0]          rs_o,
  output logic [3:0]          rt_o,
  output logic [15:0]         imm_o,
  output logic                ir_valid_o,
  output logic                fetch_busy_o,
  output logic                fetch_err_o
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [PC_W-1:0]  fetch_addr_q, fetch_addr_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             ir_valid_q, ir_valid_d;

  logic [15:0]      imm;
  logic [PC_W-1:0]  imm_zext;
  logic [PC_W-1:0]  imm_sext;
  logic [PC_W-1:0]  target;

  sisc_ir_decode u_decode (
    .ir_i     (ir_q),
    .opcode_o (opcode_o),
    .mm_o     (mm_o),
    .rd_o     (rd_o),
    .rs_o     (rs_o),
    .rt_o     (rt_o),
    .imm_o    (imm)
  );

  assign imm_o = imm;

  // Fit the 16-bit immediate to PC_W: extend when wider, truncate when narrower.
  generate
    if (PC_W > 16) begin : g_imm_wide
      assign imm_zext = {{(PC_W-16){1'b0}}, imm};
      assign imm_sext = {{(PC_W-16){imm[15]}}, imm};
    end else if (PC_W == 16) begin : g_imm_eq
      assign imm_zext = imm;
      assign imm_sext = imm;
    end else begin : g_imm_narrow
      assign imm_zext = imm[PC_W-1:0];
      assign imm_sext = imm[PC_W-1:0];
    end
  endgenerate

  // Relative add wraps naturally at PC_W bits.
  assign target = br_sel_i ? (pc_q + imm_sext) : imm_zext;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    fetch_addr_d = fetch_addr_q;
    timer_d      = timer_q;
    ir_valid_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fetch_go_i) begin
          // A simultaneous branch redirects this fetch to the target.
          fetch_addr_d = pc_write_i ? target : pc_q;
          timer_d      = '0;
          state_d      = ST_WAIT;
        end else if (pc_write_i) begin
          pc_d = target;
        end
      end
      ST_WAIT: begin
        if (imem_if.ack) begin
          // Ack wins over a timeout expiring in the same cycle.
          ir_d       = imem_if.rdata;
          pc_d       = fetch_addr_q + 1'b1;
          ir_valid_d = 1'b1;
          timer_d    = '0;
          state_d    = ST_IDLE;
        end else if ((TIMEOUT != 0) && (timer_q == TMR_LAST)) begin
          state_d = ST_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_ERR: begin
        // Terminal until reset.
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      fetch_addr_q <= RESET_PC;
      timer_q      <= '0;
      ir_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      fetch_addr_q <= fetch_addr_d;
      timer_q      <= timer_d;
      ir_valid_q   <= ir_valid_d;
    end
  end

  // req/addr decode from the registered state, so reset drops req at once.
  assign fetch_busy_o = (state_q == ST_WAIT);
  assign fetch_err_o  = (state_q == ST_ERR);
  assign imem_if.req  = fetch_busy_o;
  assign imem_if.addr = fetch_busy_o ? fetch_addr_q : '0;

  assign pc_o       = pc_q;
  assign ir_o       = ir_q;
  assign ir_valid_o = ir_valid_q;

endmodule

// File: tb/tb_sisc_fetch_unit.sv
module tb_sisc_fetch_unit;
  import sisc_pkg::*;

  localparam int PC_W = 16;
  localparam int TMO  = 8;

  logic clk = 1'b0;
  logic rst_f = 1'b0;
  logic fetch_go = 1'b0;
  logic pc_write = 1'b0;
  logic br_sel = 1'b0;

  logic [PC_W-1:0] pc;
  logic [31:0]     ir;
  logic [3:0]      opcode, mm, rd, rs, rt;
  logic [15:0]     imm;
  logic            ir_valid, fetch_busy, fetch_err;

  sisc_fetch_unit_if #(.PC_W(PC_W)) imem_bus ();

  sisc_fetch_unit #(.PC_W(PC_W), .RESET_PC(16'h0000), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst_f        (rst_f),
    .fetch_go_i   (fetch_go),
    .pc_write_i   (pc_write),
    .br_sel_i     (br_sel),
    .imem_if      (imem_bus),
    .pc_o         (pc),
    .ir_o         (ir),
    .opcode_o     (opcode),
    .mm_o         (mm),
    .rd_o         (rd),
    .rs_o         (rs),
    .rt_o         (rt),
    .imm_o        (imm),
    .ir_valid_o   (ir_valid),
    .fetch_busy_o (fetch_busy),
    .fetch_err_o  (fetch_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Transaction view: an outstanding fetch (address + cycles waited), an
  // error flag, and the architectural PC/IR as plain integers.
  int m_pc, m_ir, m_addr, m_waited;
  bit m_busy, m_err, m_valid;

  always @(posedge clk or negedge rst_f) begin
    int ival, tgt;
    if (!rst_f) begin
      m_pc = 0; m_ir = 0; m_addr = 0; m_waited = 0;
      m_busy = 0; m_err = 0; m_valid = 0;
    end else begin
      m_valid = 0;
      if (m_err) begin
        // only reset leaves the error
      end else if (m_busy) begin
        if (imem_bus.ack) begin
          m_ir = int'(imem_bus.rdata);
          m_pc = (m_addr + 1) % 65536;
          m_busy = 0;
          m_valid = 1;
        end else begin
          m_waited++;
          if (m_waited == TMO) begin
            m_busy = 0;
            m_err = 1;
          end
        end
      end else begin
        ival = m_ir & 32'hFFFF;
        if (br_sel) tgt = (m_pc + ((ival >= 32768) ? ival - 65536 : ival)) & 32'hFFFF;
        else        tgt = ival;
        if (fetch_go) begin
          m_addr = pc_write ? tgt : m_pc;
          m_busy = 1;
          m_waited = 0;
        end else if (pc_write) begin
          m_pc = tgt;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (ir_valid) vcount++;
    chk("m_pc",       32'(pc),              32'(m_pc));
    chk("m_ir",       ir,                   32'(m_ir));
    chk("m_opcode",   32'(opcode),          32'((m_ir >> 28) & 15));
    chk("m_mm",       32'(mm),              32'((m_ir >> 24) & 15));
    chk("m_rd",       32'(rd),              32'((m_ir >> 20) & 15));
    chk("m_rs",       32'(rs),              32'((m_ir >> 16) & 15));
    chk("m_rt",       32'(rt),              32'((m_ir >> 12) & 15));
    chk("m_imm",      32'(imm),             32'(m_ir & 32'hFFFF));
    chk("m_req",      32'(imem_bus.req),    32'(m_busy));
    chk("m_addr",     32'(imem_bus.addr),   m_busy ? 32'(m_addr) : 32'd0);
    chk("m_busy",     32'(fetch_busy),      32'(m_busy));
    chk("m_err",      32'(fetch_err),       32'(m_err));
    chk("m_ir_valid", 32'(ir_valid),        32'(m_valid));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue fetch_go (optionally with pc_write), ack after 'gap' extra WAIT
  // cycles with 'word'. Returns the address seen on the bus.
  task automatic do_fetch(input logic pcw, input logic br, input int gap,
                          input logic [31:0] word, output logic [15:0] addr_seen);
    int v0;
    fetch_go = 1'b1; pc_write = pcw; br_sel = br;
    tick();
    fetch_go = 1'b0; pc_write = 1'b0; br_sel = 1'b0;
    addr_seen = imem_bus.addr;
    chk("req_in_wait", 32'(imem_bus.req), 32'd1);
    repeat (gap) begin
      tick();
      chk("addr_stable", 32'(imem_bus.addr), 32'(addr_seen));
    end
    v0 = vcount;
    imem_bus.ack = 1'b1; imem_bus.rdata = word;
    tick();
    imem_bus.ack = 1'b0; imem_bus.rdata = 32'h0;
    chk("ir_valid_pulse", 32'(ir_valid), 32'd1);
    tick();
    chk("ir_valid_once", 32'(vcount - v0), 32'd1);
    $display("fetch addr=%04h word=%08h pc=%04h", addr_seen, word, pc);
  endtask

  task automatic branch(input logic br);
    pc_write = 1'b1; br_sel = br;
    tick();
    pc_write = 1'b0; br_sel = 1'b0;
    $display("branch %s pc=%04h", br ? "rel" : "abs", pc);
  endtask

  initial begin
    logic [15:0] a;
    int v0;
    imem_bus.ack = 1'b0;
    imem_bus.rdata = 32'h0;

    // Reset state
    repeat (2) tick();
    chk("rst_pc",  32'(pc), 32'h0);
    chk("rst_ir",  ir, 32'h0);
    chk("rst_req", 32'(imem_bus.req), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    rst_f = 1'b1;
    tick();

    // 1: basic fetch, ack 2 cycles after fetch_go
    do_fetch(1'b0, 1'b0, 1, 32'h10230005, a);
    chk("t1_addr",   32'(a), 32'h0000);
    chk("t1_opcode", 32'(opcode), 32'(OP_ALU));
    chk("t1_mm",     32'(mm), 32'h0);
    chk("t1_rd",     32'(rd), 32'h2);
    chk("t1_rs",     32'(rs), 32'h3);
    chk("t1_imm",    32'(imm), 32'h0005);
    chk("t1_pc",     32'(pc), 32'h0001);

    // 2: absolute branch then fetch from target
    do_fetch(1'b0, 1'b0, 0, 32'h00000040, a);
    branch(1'b0);
    chk("t2_pc", 32'(pc), 32'h0040);
    do_fetch(1'b0, 1'b0, 2, 32'h0000000F, a);
    chk("t2_addr", 32'(a), 32'h0040);

    // 3: relative branches, including wrap below zero
    branch(1'b0);                                  // pc = 0x000F
    do_fetch(1'b0, 1'b0, 0, 32'h0000FFFC, a);      // pc = 0x0010
    branch(1'b1);
    chk("t3_rel", 32'(pc), 32'h000C);
    do_fetch(1'b0, 1'b0, 0, 32'h00000001, a);
    branch(1'b0);                                  // pc = 0x0001
    do_fetch(1'b0, 1'b0, 0, 32'h0000FFFC, a);      // pc = 0x0002
    chk("t3_pc2", 32'(pc), 32'h0002);
    branch(1'b1);
    chk("t3_wrap", 32'(pc), 32'hFFFE);

    // 6: fetch_go with pc_write from pc=0x0005, imm=0x0100
    do_fetch(1'b0, 1'b0, 0, 32'h00000004, a);
    branch(1'b0);                                  // pc = 0x0004
    do_fetch(1'b0, 1'b0, 0, 32'h00000100, a);      // pc = 0x0005
    chk("t6_pc0", 32'(pc), 32'h0005);
    do_fetch(1'b1, 1'b0, 1, 32'hF0000000, a);
    chk("t6_addr", 32'(a), 32'h0100);
    chk("t6_pc",   32'(pc), 32'h0101);

    // 5: reset mid-WAIT, late ack ignored
    fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    tick();
    chk("t5_busy", 32'(fetch_busy), 32'd1);
    #2 rst_f = 1'b0;
    #1;
    chk("t5_req_async", 32'(imem_bus.req), 32'd0);
    chk("t5_pc",        32'(pc), 32'h0000);
    chk("t5_ir",        ir, 32'h0);
    tick();
    rst_f = 1'b1;
    v0 = vcount;
    tick();
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'h12345678;
    tick();
    imem_bus.ack = 1'b0; imem_bus.rdata = 32'h0;
    tick();
    chk("t5_no_valid", 32'(vcount - v0), 32'd0);
    chk("t5_ir_kept",  ir, 32'h0);
    $display("reset mid-wait pc=%04h ir=%08h", pc, ir);

    // 4: timeout after TMO WAIT cycles, then everything ignored
    fetch_go = 1'b1; tick(); fetch_go = 1'b0;     // WAIT cycle 1
    repeat (TMO - 1) tick();                       // WAIT cycle TMO
    chk("t4_busy_last", 32'(fetch_busy), 32'd1);
    chk("t4_err_early", 32'(fetch_err), 32'd0);
    tick();
    chk("t4_err", 32'(fetch_err), 32'd1);
    chk("t4_req", 32'(imem_bus.req), 32'd0);
    v0 = vcount;
    fetch_go = 1'b1; tick(); fetch_go = 1'b0;
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'hAAAA5555;
    repeat (2) tick();
    imem_bus.ack = 1'b0;
    tick();
    chk("t4_no_valid", 32'(vcount - v0), 32'd0);
    chk("t4_err_sticky", 32'(fetch_err), 32'd1);
    $display("timeout err=%0d pc=%04h", fetch_err, pc);

    rst_f = 1'b0;
    tick();
    chk("t4_err_clr", 32'(fetch_err), 32'd0);
    rst_f = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
